// File: rtl/i2c_sht40_target.sv
// rtl/i2c_sht40_target.sv - I2C target emulating an SHT40 measurement/readout sequence.
// SHT40_TARGET_CRC_EN enables real CRC-8 bytes in the read frame; otherwise both CRC bytes read as 8'hFF.
module i2c_sht40_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter logic [15:0] MEAS_CYCLES = 16'd200
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Scl_In,
  input  logic        Sda_In,
  input  logic [15:0] Temp_Word,
  input  logic [15:0] Hum_Word,
  output logic        Sda_Drive_Low,
  output logic        Cmd_Valid,
  output logic [7:0]  Cmd_Byte,
  output logic        Busy,
  output logic [2:0]  Bytes_Sent,
  output logic [2:0]  Target_State_Out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_ADDR      = 3'b001,
    S_ADDR_ACK  = 3'b010,
    S_WRITE     = 3'b011,
    S_WRITE_ACK = 3'b100,
    S_READ_TX   = 3'b101,
    S_READ_ACK  = 3'b110,
    S_WAIT_STOP = 3'b111
  } state_t;

  state_t      state, state_nxt;
  logic        scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt, rx_byte, tx_byte, cmd_byte_nxt;
  logic        sda_low_nxt, ack_on, ack_on_nxt, cmd_valid_nxt, addr_ok, clr_pending;
  logic [2:0]  bytes_sent_nxt;
  logic        pending, done_d;
  logic [15:0] cnt, t_lat, h_lat;
  logic [7:0]  crc_t, crc_h;

  always_ff @(posedge clk) begin
    if (Rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {Scl_In, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {Sda_In, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

`ifdef SHT40_TARGET_CRC_EN
  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      c = (c[7] ^ w[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
  assign crc_t = crc8(t_lat);
  assign crc_h = crc8(h_lat);
`else
  assign crc_t = 8'hFF;
  assign crc_h = 8'hFF;
`endif

  always_comb begin
    case (Bytes_Sent)
      3'd0:    tx_byte = t_lat[15:8];
      3'd1:    tx_byte = t_lat[7:0];
      3'd2:    tx_byte = crc_t;
      3'd3:    tx_byte = h_lat[15:8];
      3'd4:    tx_byte = h_lat[7:0];
      default: tx_byte = crc_h;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      Sda_Drive_Low <= 1'b0;
      ack_on        <= 1'b0;
      Cmd_Valid     <= 1'b0;
      Cmd_Byte      <= '0;
      Bytes_Sent    <= '0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shift         <= shift_nxt;
      Sda_Drive_Low <= sda_low_nxt;
      ack_on        <= ack_on_nxt;
      Cmd_Valid     <= cmd_valid_nxt;
      Cmd_Byte      <= cmd_byte_nxt;
      Bytes_Sent    <= bytes_sent_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    sda_low_nxt    = Sda_Drive_Low;
    ack_on_nxt     = ack_on;
    cmd_valid_nxt  = 1'b0;
    cmd_byte_nxt   = Cmd_Byte;
    bytes_sent_nxt = Bytes_Sent;
    clr_pending    = 1'b0;
    rx_byte        = {shift[6:0], sda_s2};
    addr_ok        = (rx_byte[7:1] == TARGET_ADDR) && (!rx_byte[0] || (pending && !Busy));
    if (start_det) begin
      state_nxt   = S_ADDR;
      bit_cnt_nxt = '0;
      sda_low_nxt = 1'b0;
      ack_on_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt      = S_IDLE;
      sda_low_nxt    = 1'b0;
      ack_on_nxt     = 1'b0;
      bytes_sent_nxt = '0;
    end else begin
      case (state)
        S_ADDR, S_WRITE: if (scl_rise) begin
          shift_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (state == S_WRITE) state_nxt = S_WRITE_ACK;
            else                  state_nxt = addr_ok ? S_ADDR_ACK : S_WAIT_STOP;
          end
        end
        // First falling edge starts the ACK pulse, the second ends it.
        S_ADDR_ACK, S_WRITE_ACK: if (scl_fall) begin
          if (!ack_on) begin
            sda_low_nxt = 1'b1;
            ack_on_nxt  = 1'b1;
            if (state == S_WRITE_ACK) begin
              cmd_valid_nxt = 1'b1;
              cmd_byte_nxt  = shift;
            end
          end else begin
            ack_on_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            sda_low_nxt = 1'b0;
            state_nxt   = S_WRITE;
            if (state == S_ADDR_ACK && shift[0]) begin
              state_nxt      = S_READ_TX;
              sda_low_nxt    = ~t_lat[15];
              bit_cnt_nxt    = 4'd1;
              bytes_sent_nxt = '0;
            end
          end
        end
        S_READ_TX: if (scl_fall) begin
          if (bit_cnt[3]) begin
            sda_low_nxt = 1'b0;
            state_nxt   = S_READ_ACK;
          end else begin
            sda_low_nxt = ~tx_byte[3'd7 - bit_cnt[2:0]];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bytes_sent_nxt = Bytes_Sent + 3'd1;
              clr_pending    = (Bytes_Sent == 3'd5);
            end
          end
        end
        S_READ_ACK: if (scl_rise) begin
          if (!sda_s2 && Bytes_Sent < 3'd6) begin
            state_nxt   = S_READ_TX;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  // pending follows Busy by one clk, so a read decided as Busy drops is still refused.
  always_ff @(posedge clk) begin
    if (Rst) begin
      Busy    <= 1'b0;
      cnt     <= '0;
      pending <= 1'b0;
      done_d  <= 1'b0;
      t_lat   <= '0;
      h_lat   <= '0;
    end else begin
      done_d <= 1'b0;
      if (Cmd_Valid && Cmd_Byte == MEAS_CMD) begin
        t_lat   <= Temp_Word;
        h_lat   <= Hum_Word;
        Busy    <= 1'b1;
        cnt     <= MEAS_CYCLES;
        pending <= 1'b0;
      end else begin
        if (Busy) begin
          if (cnt == 16'd1) begin
            Busy   <= 1'b0;
            done_d <= 1'b1;
          end
          cnt <= cnt - 16'd1;
        end
        if (done_d)      pending <= 1'b1;
        if (clr_pending) pending <= 1'b0;
      end
    end
  end

  assign Target_State_Out = state;

endmodule

// File: tb/tb_i2c_sht40_target.sv
// tb/tb_i2c_sht40_target.sv - directed bench for i2c_sht40_target with a bit-banged I2C master.
module tb_i2c_sht40_target;
  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic [15:0] temp_w = 16'hBEEF;
  logic [15:0] hum_w = 16'h6666;
  logic        sda_drive_low, cmd_valid, busy;
  logic [7:0]  cmd_byte;
  logic [2:0]  bytes_sent, state_out;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0, cv_count = 0, cv_cyc = 0, busy_cycles = 0, b_rise = 0;
  logic busy_q = 1'b0;

  assign sda_line = sda_m & ~sda_drive_low;

  i2c_sht40_target dut (
    .clk(clk), .Rst(rst), .Scl_In(scl), .Sda_In(sda_line),
    .Temp_Word(temp_w), .Hum_Word(hum_w),
    .Sda_Drive_Low(sda_drive_low), .Cmd_Valid(cmd_valid), .Cmd_Byte(cmd_byte),
    .Busy(busy), .Bytes_Sent(bytes_sent), .Target_State_Out(state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid) begin
      cv_count = cv_count + 1;
      cv_cyc = cyc;
    end
    if (busy) busy_cycles = busy_cycles + 1;
    if (busy && !busy_q) b_rise = cyc;
    busy_q = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(); scl = 1'b1; wq(); sda_m = 1'b0; wq(); scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(); scl = 1'b1; wq(); b = sda_line; wq(); scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bt;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(bt);
    ack = ~bt;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic give_ack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    write_bit(~give_ack);
  endtask

  task automatic wait_busy_low();
    int k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("busy_timeout", busy, 1'b0);
  endtask

  logic [7:0] exp_frame [6];
  logic [7:0] rb;
  logic       ack;
  int         cv0, bc0;

  initial begin
`ifdef SHT40_TARGET_CRC_EN
    exp_frame = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93};
`else
    exp_frame = '{8'hBE, 8'hEF, 8'hFF, 8'h66, 8'h66, 8'hFF};
`endif
    repeat (4) @(negedge clk);
    chk("rst_sda", sda_drive_low, 1'b0);
    chk("rst_state", state_out, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bytes", bytes_sent, 3'd0);
    chk("rst_cv", cmd_valid, 1'b0);
    chk("rst_cmd", cmd_byte, 8'h00);
    rst = 1'b0;
    wq();

    cv0 = cv_count; bc0 = busy_cycles;
    i2c_start();
    write_byte(8'h88, ack); chk("w_addr_ack", ack, 1'b1);
    write_byte(8'hFD, ack); chk("w_cmd_ack", ack, 1'b1);
    i2c_stop(); wq();
    chk("w_state_idle", state_out, 3'b000);
    chk("w_cmd_byte", cmd_byte, 8'hFD);
    chk("w_cv_once", cv_count - cv0, 1);
    chk("busy_after_cv", b_rise, cv_cyc + 1);
    chk("busy_high", busy, 1'b1);

    i2c_start();
    write_byte(8'h89, ack); chk("busy_read_nack", ack, 1'b0);
    chk("busy_read_state", state_out, 3'b111);
    chk("busy_still", busy, 1'b1);
    i2c_stop(); wq();
    chk("busy_read_idle", state_out, 3'b000);
    wait_busy_low();
    chk("busy_len", busy_cycles - bc0, 200);

    repeat (50) @(negedge clk);
    i2c_start();
    write_byte(8'h89, ack); chk("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < 6; i++) begin
      read_byte(rb, i < 5);
      chk($sformatf("rd_byte%0d", i), rb, exp_frame[i]);
    end
    chk("rd_bytes_sent", bytes_sent, 3'd6);
    chk("rd_wait_stop", state_out, 3'b111);
    i2c_stop(); wq();
    chk("rd_bytes_clr", bytes_sent, 3'd0);
    i2c_start();
    write_byte(8'h89, ack); chk("reread_nack", ack, 1'b0);
    i2c_stop(); wq();

    cv0 = cv_count;
    i2c_start();
    write_byte(8'h8A, ack); chk("bad_addr_nack", ack, 1'b0);
    chk("bad_addr_state", state_out, 3'b111);
    i2c_stop(); wq();
    chk("bad_addr_no_cv", cv_count - cv0, 0);

    temp_w = 16'h1234; hum_w = 16'hABCD;
    i2c_start();
    write_byte(8'h88, ack);
    write_byte(8'hFD, ack); chk("m2_cmd_ack", ack, 1'b1);
    i2c_stop();
    wait_busy_low();
    repeat (5) @(negedge clk);
    i2c_start();
    write_byte(8'h89, ack); chk("m2_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b1); chk("m2_byte0", rb, 8'h12);
    read_byte(rb, 1'b0); chk("m2_byte1", rb, 8'h34);
    chk("m2_nack_sda", sda_drive_low, 1'b0);
    chk("m2_nack_state", state_out, 3'b111);
    i2c_stop(); wq();
    chk("m2_stop_idle", state_out, 3'b000);
    i2c_start();
    write_byte(8'h88, ack); chk("rs_first_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'h88, ack); chk("rs_second_ack", ack, 1'b1);
    chk("rs_write_state", state_out, 3'b011);
    i2c_stop(); wq();

    i2c_start();
    write_byte(8'h89, ack); chk("rt_addr_ack", ack, 1'b1);
    chk("rt_state_tx", state_out, 3'b101);
    chk("rt_sda_low", sda_drive_low, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rt_sda_rel", sda_drive_low, 1'b0);
    chk("rt_state_idle", state_out, 3'b000);
    chk("rt_busy", busy, 1'b0);
    rst = 1'b0;
    scl = 1'b1; sda_m = 1'b1;
    wq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
